button_input_bank: RTL and testbench

Parametrised front-end that conditions N raw push-button inputs into clean control events for the game and cursor logic. Each channel gets a two-flop synchroniser and a debouncer. Each channel then produces a debounced level, one-cycle press and release pulses, and an optional auto-repeat pulse train for held buttons. It replaces the per-button debouncer instances at the top level, and its repeat outputs drive the cursor mover directly.

---
 rtl/button_pkg.sv | 19 +
 rtl/debounce_channel.sv | 111 +++++++++++
 rtl/button_input_bank.sv | 40 ++++
 tb/tb_button_input_bank.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared channel indices and repeat FSM state type for the button bank
package button_pkg;

  localparam int BTN_UP      = 0;
  localparam int BTN_DOWN    = 1;
  localparam int BTN_LEFT    = 2;
  localparam int BTN_RIGHT   = 3;
  localparam int BTN_ACTION  = 4;
  localparam int BTN_LINKS   = 5;
  localparam int BTN_RECHTS  = 6;
  localparam int BTN_ZENTRUM = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    RATE  = 2'd2
  } repState_t;

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one button: synchroniser, debouncer, edge pulses, auto-repeat FSM
module debounce_channel
  import button_pkg::*;
#(
  parameter int DEB_CYCLES   = 50000,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000,
  parameter bit REPEAT_EN    = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic btnRaw,
  output logic btnState,
  output logic btnPress,
  output logic btnRelease,
  output logic btnRepeat
);

  localparam int DW   = $clog2(DEB_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_LOAD = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_LOAD  = RW'(REPEAT_RATE - 1);

  logic [1:0]    syncFf;
  logic [DW-1:0] debCnt;
  logic          disagree;
  logic          flip;
  logic          rise;
  logic          fall;
  repState_t     repState;
  repState_t     repNext;
  logic [RW-1:0] repCnt;
  logic [RW-1:0] repCntNext;
  logic          repeatNext;

  assign disagree = syncFf[1] ^ btnState;
  assign flip     = disagree && (debCnt == DEB_LAST);
  assign rise     = flip && !btnState;
  assign fall     = flip && btnState;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      syncFf     <= '0;
      debCnt     <= '0;
      btnState   <= 1'b0;
      btnPress   <= 1'b0;
      btnRelease <= 1'b0;
    end else begin
      syncFf     <= {syncFf[0], btnRaw};
      // Any agreeing cycle restarts the count, so short glitches never flip the level
      debCnt     <= (!disagree || flip) ? '0 : debCnt + DW'(1);
      btnState   <= btnState ^ flip;
      btnPress   <= rise;
      btnRelease <= fall;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      repState  <= IDLE;
      repCnt    <= '0;
      btnRepeat <= 1'b0;
    end else begin
      repState  <= repNext;
      repCnt    <= repCntNext;
      btnRepeat <= repeatNext;
    end
  end

  always_comb begin
    repNext    = repState;
    repCntNext = repCnt;
    repeatNext = 1'b0;
    case (repState)
      IDLE: begin
        if (rise) begin
          repNext    = DELAY;
          repCntNext = DELAY_LOAD;
          repeatNext = 1'b1;
        end
      end
      DELAY: begin
        if (repCnt != '0) begin
          repCntNext = repCnt - RW'(1);
        end else if (REPEAT_EN) begin
          repNext    = RATE;
          repCntNext = RATE_LOAD;
          repeatNext = 1'b1;
        end
      end
      RATE: begin
        if (repCnt != '0) begin
          repCntNext = repCnt - RW'(1);
        end else begin
          repCntNext = RATE_LOAD;
          repeatNext = 1'b1;
        end
      end
      default: repNext = IDLE;
    endcase
    // Release wins over any pending repeat pulse
    if (fall) begin
      repNext    = IDLE;
      repCntNext = '0;
      repeatNext = 1'b0;
    end
  end

endmodule

// File: rtl/button_input_bank.sv
// rtl/button_input_bank.sv - bank of independent debounced button channels with press summary
module button_input_bank
  import button_pkg::*;
#(
  parameter int               N_BTN        = 8,
  parameter int               DEB_CYCLES   = 50000,
  parameter int               REPEAT_DELAY = 25000000,
  parameter int               REPEAT_RATE  = 5000000,
  parameter logic [N_BTN-1:0] REPEAT_MASK  = 8'b0000_1111
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_state,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat,
  output logic             any_press
);

  for (genvar i = 0; i < N_BTN; i++) begin : gChan
    debounce_channel #(
      .DEB_CYCLES  (DEB_CYCLES),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE (REPEAT_RATE),
      .REPEAT_EN   (REPEAT_MASK[i])
    ) uChan (
      .clk       (clk),
      .reset     (reset),
      .btnRaw    (btn_in[i]),
      .btnState  (btn_state[i]),
      .btnPress  (btn_press[i]),
      .btnRelease(btn_release[i]),
      .btnRepeat (btn_repeat[i])
    );
  end

  assign any_press = |btn_press;

endmodule

// File: tb/tb_button_input_bank.sv
// tb/tb_button_input_bank.sv - randomized and directed bench for button_input_bank
module tb_button_input_bank;

  localparam int DEB = 4;
  localparam int DLY = 10;
  localparam int RTE = 3;
  localparam logic [7:0] MASK = 8'h0F;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] btn_in;
  logic [7:0] btn_state, btn_press, btn_release, btn_repeat;
  logic       any_press;

  int compared = 0;
  int mismatched = 0;
  int edgeIdx = 0;

  bit   s1[8], s2[8], st[8];
  int   run[8], pressEdge[8];
  logic [7:0] mState, mPress, mRel, mRep;

  button_input_bank #(
    .N_BTN(8), .DEB_CYCLES(DEB), .REPEAT_DELAY(DLY), .REPEAT_RATE(RTE), .REPEAT_MASK(MASK)
  ) dut (
    .clk(clk), .reset(reset), .btn_in(btn_in), .btn_state(btn_state), .btn_press(btn_press),
    .btn_release(btn_release), .btn_repeat(btn_repeat), .any_press(any_press)
  );

  always #5 clk = ~clk;

  function automatic void modelReset();
    for (int i = 0; i < 8; i++) begin
      s1[i] = 0; s2[i] = 0; st[i] = 0; run[i] = 0; pressEdge[i] = 0;
    end
    mState = '0; mPress = '0; mRel = '0; mRep = '0;
  endfunction

  // Level flips after DEB consecutive sampled disagreements; repeats follow press time arithmetic
  function automatic void modelEdge(input logic [7:0] v);
    for (int i = 0; i < 8; i++) begin
      bit seen;
      int el;
      seen = s2[i];
      s2[i] = s1[i];
      s1[i] = v[i];
      run[i] = (seen != st[i]) ? run[i] + 1 : 0;
      mPress[i] = 1'b0;
      mRel[i] = 1'b0;
      if (run[i] == DEB) begin
        st[i] = !st[i];
        run[i] = 0;
        if (st[i]) begin
          mPress[i] = 1'b1;
          pressEdge[i] = edgeIdx;
        end else begin
          mRel[i] = 1'b1;
        end
      end
      mState[i] = st[i];
      el = edgeIdx - pressEdge[i];
      mRep[i] = st[i] && (mPress[i] || (MASK[i] && el >= DLY && ((el - DLY) % RTE) == 0));
    end
  endfunction

  task automatic checkAll(input string tag);
    compared += 5;
    if (btn_state !== mState) begin
      mismatched++; $display("FAIL %s btn_state got %b want %b", tag, btn_state, mState);
    end
    if (btn_press !== mPress) begin
      mismatched++; $display("FAIL %s btn_press got %b want %b", tag, btn_press, mPress);
    end
    if (btn_release !== mRel) begin
      mismatched++; $display("FAIL %s btn_release got %b want %b", tag, btn_release, mRel);
    end
    if (btn_repeat !== mRep) begin
      mismatched++; $display("FAIL %s btn_repeat got %b want %b", tag, btn_repeat, mRep);
    end
    if (any_press !== (|mPress)) begin
      mismatched++; $display("FAIL %s any_press got %b want %b", tag, any_press, |mPress);
    end
  endtask

  task automatic tick(input logic [7:0] v, input string tag);
    btn_in = v;
    @(posedge clk);
    if (reset) modelReset();
    else modelEdge(v);
    edgeIdx++;
    #1;
    checkAll(tag);
  endtask

  task automatic settle();
    repeat (12) tick(8'h00, "settle");
  endtask

  task automatic test_reset();
    reset = 1'b1;
    btn_in = '0;
    modelReset();
    #3;
    compared++;
    if ({btn_state, btn_press, btn_release, btn_repeat, any_press} !== '0) begin
      mismatched++; $display("FAIL reset_outputs got %h want 0", {btn_state, btn_press, btn_release, btn_repeat});
    end
    repeat (2) tick(8'h00, "reset_hold");
    #2 reset = 1'b0;
  endtask

  task automatic test_clean_press();
    settle();
    for (int k = 0; k < 10; k++) begin
      tick(8'h01, "clean");
      compared += 3;
      if (btn_state[0] !== (k + 1 >= 6)) begin
        mismatched++; $display("FAIL clean_state c=%0d got %b want %b", k + 1, btn_state[0], k + 1 >= 6);
      end
      if (btn_press[0] !== (k + 1 == 6)) begin
        mismatched++; $display("FAIL clean_press c=%0d got %b want %b", k + 1, btn_press[0], k + 1 == 6);
      end
      if (any_press !== (k + 1 == 6)) begin
        mismatched++; $display("FAIL clean_any c=%0d got %b want %b", k + 1, any_press, k + 1 == 6);
      end
    end
  endtask

  task automatic test_bounce();
    settle();
    for (int k = 0; k < 32; k++) begin
      logic [7:0] v;
      v = (k >= 20 || (k % 4) != 3) ? 8'h02 : 8'h00;
      tick(v, "bounce");
      compared += 2;
      if (btn_press[1] !== (k == 25)) begin
        mismatched++; $display("FAIL bounce_press k=%0d got %b want %b", k, btn_press[1], k == 25);
      end
      if (btn_state[1] !== (k >= 25)) begin
        mismatched++; $display("FAIL bounce_state k=%0d got %b want %b", k, btn_state[1], k >= 25);
      end
    end
  endtask

  task automatic test_repeat(input int ch);
    int relCount;
    relCount = 0;
    settle();
    for (int k = 0; k < 56; k++) begin
      int c;
      logic expRep;
      tick((k < 40) ? (8'h01 << ch) : 8'h00, "repeat");
      c = k + 1;
      expRep = (c == 6) || (MASK[ch] && c >= 16 && c <= 43 && ((c - 16) % 3) == 0);
      relCount += int'(btn_release[ch]);
      compared += 2;
      if (btn_repeat[ch] !== expRep) begin
        mismatched++; $display("FAIL repeat_ch%0d c=%0d got %b want %b", ch, c, btn_repeat[ch], expRep);
      end
      if (btn_release[ch] !== (c == 46)) begin
        mismatched++; $display("FAIL release_ch%0d c=%0d got %b want %b", ch, c, btn_release[ch], c == 46);
      end
    end
    compared++;
    if (relCount != 1) begin
      mismatched++; $display("FAIL release_count_ch%0d got %0d want 1", ch, relCount);
    end
  endtask

  task automatic test_simultaneous();
    int anyCount;
    anyCount = 0;
    settle();
    for (int k = 0; k < 10; k++) begin
      tick(8'hA0, "simul");
      anyCount += int'(any_press);
      compared++;
      if (btn_press !== ((k + 1 == 6) ? 8'hA0 : 8'h00)) begin
        mismatched++; $display("FAIL simul_press c=%0d got %b", k + 1, btn_press);
      end
    end
    compared++;
    if (anyCount != 1) begin
      mismatched++; $display("FAIL simul_any_count got %0d want 1", anyCount);
    end
  endtask

  task automatic test_reset_mid();
    settle();
    repeat (20) tick(8'h08, "mid_hold");
    #2 reset = 1'b1;
    #1;
    compared++;
    if ({btn_state, btn_press, btn_release, btn_repeat, any_press} !== '0) begin
      mismatched++; $display("FAIL mid_reset_outputs got %h want 0", {btn_state, btn_press, btn_release, btn_repeat});
    end
    repeat (2) tick(8'h08, "mid_reset");
    #2 reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick(8'h08, "mid_after");
      compared++;
      if (btn_press[3] !== (k + 1 == 6)) begin
        mismatched++; $display("FAIL mid_press c=%0d got %b want %b", k + 1, btn_press[3], k + 1 == 6);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] lvl;
    int dur[8];
    lvl = '0;
    for (int i = 0; i < 8; i++) dur[i] = 0;
    settle();
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < 8; i++) begin
        if (dur[i] == 0) begin
          lvl[i] = 1'($urandom_range(0, 1));
          dur[i] = int'($urandom_range(1, 24));
        end
        dur[i]--;
      end
      tick(lvl, "random");
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_repeat(2);
    test_repeat(4);
    test_simultaneous();
    test_reset_mid();
    test_random();
    settle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
